// File: rtl/sync_fifo_mc.sv
// Single-clock multi-channel FIFO: NUM_CH independent FIFOs with fill count,
// almost-full/almost-empty decodes, sticky overflow/underflow, per-channel
// flush and an optional first-word-fall-through read port.
module sync_fifo_mc #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_CH-1:0]              full,
    output logic [NUM_CH-1:0]              almost_full,
    input  logic [NUM_CH-1:0]              rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_CH-1:0]              empty,
    output logic [NUM_CH-1:0]              almost_empty,
    output logic [NUM_CH*CNT_WIDTH-1:0]    count,
    input  logic [NUM_CH-1:0]              flush,
    input  logic                           clr_err,
    output logic [NUM_CH-1:0]              overflow,
    output logic [NUM_CH-1:0]              underflow
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    // Reject illegal parameterisations at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_mc: DEPTH must be a power of 2 and >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("sync_fifo_mc: NUM_CH must be >= 1");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_mc: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_mc: AE_THRESH must be in 0..DEPTH-1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PTR_WIDTH-1:0]  wr_ptr;
        logic [PTR_WIDTH-1:0]  rd_ptr;
        logic [CNT_WIDTH-1:0]  cnt;
        logic                  is_full;
        logic                  is_empty;
        logic                  wr_acc;
        logic                  rd_acc;
        logic                  ovf_set;
        logic                  unf_set;

        // Status flags decode only the registered fill count.
        assign is_full  = (cnt == CNT_WIDTH'(DEPTH));
        assign is_empty = (cnt == '0);

        // Flush takes the channel out of service for the cycle: no accepts, no errors.
        assign wr_acc  = wr_en[c] && !is_full  && !flush[c];
        assign rd_acc  = rd_en[c] && !is_empty && !flush[c];
        assign ovf_set = wr_en[c] &&  is_full  && !flush[c];
        assign unf_set = rd_en[c] &&  is_empty && !flush[c];

        assign full[c]         = is_full;
        assign empty[c]        = is_empty;
        assign almost_full[c]  = (cnt >= CNT_WIDTH'(AF_THRESH));
        assign almost_empty[c] = (cnt <= CNT_WIDTH'(AE_THRESH));
        assign count[c*CNT_WIDTH +: CNT_WIDTH] = cnt;

        // Pointers and fill count; pointers wrap naturally at DEPTH.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else if (flush[c]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_WIDTH'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + PTR_WIDTH'(1);
                end
                cnt <= cnt + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_acc);
            end
        end

        // Storage array, intentionally left out of reset.
        always_ff @(posedge clk) begin
            if (rst_n && wr_acc) begin
                mem[wr_ptr] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Sticky error bits; a new error in the clearing cycle wins.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                overflow[c]  <= 1'b0;
                underflow[c] <= 1'b0;
            end else begin
                if (ovf_set) begin
                    overflow[c] <= 1'b1;
                end else if (clr_err) begin
                    overflow[c] <= 1'b0;
                end
                if (unf_set) begin
                    underflow[c] <= 1'b1;
                end else if (clr_err) begin
                    underflow[c] <= 1'b0;
                end
            end
        end

        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly, masked to zero while empty.
            assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = is_empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_q;

            // Registered read port: load head word on an accepted pop, else hold.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else if (rd_acc) begin
                    rd_q <= mem[rd_ptr];
                end
            end

            assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_mc.sv
// Self-checking bench for sync_fifo_mc: directed scenarios plus randomized
// traffic, checked every cycle against a queue-based reference model.
// A second FWFT=1 instance shares all inputs and has its read port checked too.
module tb_sync_fifo_mc;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CW    = 5;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    wr_en;
    logic [NCH*DW-1:0] wr_data;
    logic [NCH-1:0]    rd_en;
    logic [NCH-1:0]    flush;
    logic              clr_err;

    logic [NCH-1:0]    full, almost_full, empty, almost_empty, overflow, underflow;
    logic [NCH*DW-1:0] rd_data;
    logic [NCH*CW-1:0] count;

    logic [NCH-1:0]    f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow;
    logic [NCH*DW-1:0] f_rd_data;
    logic [NCH*CW-1:0] f_count;

    always #5 clk = ~clk;

    sync_fifo_mc dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .almost_empty(almost_empty), .count(count), .flush(flush), .clr_err(clr_err),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_mc #(.FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(f_full),
        .almost_full(f_almost_full), .rd_en(rd_en), .rd_data(f_rd_data), .empty(f_empty),
        .almost_empty(f_almost_empty), .count(f_count), .flush(flush), .clr_err(clr_err),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    // Reference model: one queue per channel plus last-popped word and stickies.
    logic [DW-1:0] q [NCH][$];
    logic [DW-1:0] m_rd  [NCH];
    logic          m_ovf [NCH];
    logic          m_unf [NCH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h at %0t", tag, ch, obs, exp, $time);
        end
    endtask

    function automatic void model_step();
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                q[c].delete();
                m_rd[c]  = '0;
                m_ovf[c] = 1'b0;
                m_unf[c] = 1'b0;
            end else if (flush[c]) begin
                q[c].delete();
                if (clr_err) begin
                    m_ovf[c] = 1'b0;
                    m_unf[c] = 1'b0;
                end
            end else begin
                int  sz;
                bit  ovf_ev, unf_ev;
                sz     = q[c].size();
                ovf_ev = wr_en[c] && (sz == DEPTH);
                unf_ev = rd_en[c] && (sz == 0);
                if (rd_en[c] && sz > 0) m_rd[c] = q[c].pop_front();
                if (wr_en[c] && sz < DEPTH) q[c].push_back(wr_data[c*DW +: DW]);
                if (ovf_ev) m_ovf[c] = 1'b1; else if (clr_err) m_ovf[c] = 1'b0;
                if (unf_ev) m_unf[c] = 1'b1; else if (clr_err) m_unf[c] = 1'b0;
            end
        end
    endfunction

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            int sz;
            logic [DW-1:0] head;
            sz   = q[c].size();
            head = (sz > 0) ? q[c][0] : '0;
            check("count",        c, 32'(count[c*CW +: CW]), 32'(sz));
            check("full",         c, 32'(full[c]),           32'(sz == DEPTH));
            check("empty",        c, 32'(empty[c]),          32'(sz == 0));
            check("almost_full",  c, 32'(almost_full[c]),    32'(sz >= AF));
            check("almost_empty", c, 32'(almost_empty[c]),   32'(sz <= AE));
            check("overflow",     c, 32'(overflow[c]),       32'(m_ovf[c]));
            check("underflow",    c, 32'(underflow[c]),      32'(m_unf[c]));
            check("rd_data",      c, 32'(rd_data[c*DW +: DW]), 32'(m_rd[c]));
            check("fwft_rd_data", c, 32'(f_rd_data[c*DW +: DW]), 32'(head));
            check("fwft_count",   c, 32'(f_count[c*CW +: CW]), 32'(sz));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst_n   = 1'b1;
        wr_en   = '0;
        rd_en   = '0;
        flush   = '0;
        clr_err = 1'b0;
    endtask

    task automatic put(input int ch, input logic [DW-1:0] d);
        idle();
        wr_en[ch] = 1'b1;
        wr_data[ch*DW +: DW] = d;
        tick();
    endtask

    task automatic pop(input int ch);
        idle();
        rd_en[ch] = 1'b1;
        tick();
    endtask

    initial begin
        wr_data = '0;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_empty", -1, 32'(empty), 32'(4'hF));
        check("rst_almost_empty", -1, 32'(almost_empty), 32'(4'hF));
        idle();

        // 1. Fill ch0, overflow, drain in order.
        for (int i = 0; i < 16; i++) begin
            put(0, DW'(i));
            if (i == 12) check("t1_af_below", 0, 32'(almost_full[0]), 32'd0);
            if (i == 13) check("t1_af_at14", 0, 32'(almost_full[0]), 32'd1);
            if (i == 14) check("t1_not_full15", 0, 32'(full[0]), 32'd0);
        end
        check("t1_full", 0, 32'(full[0]), 32'd1);
        put(0, 8'hAA);
        check("t1_overflow", 0, 32'(overflow[0]), 32'd1);
        check("t1_count16", 0, 32'(count[0 +: CW]), 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop(0);
            check("t1_drain", 0, 32'(rd_data[0 +: DW]), 32'(i));
        end

        // 2. Wrap on ch1.
        for (int i = 0; i < 10; i++) put(1, DW'(8'h40 + i));
        for (int i = 0; i < 10; i++) pop(1);
        for (int i = 0; i < 16; i++) put(1, DW'(8'h80 + i));
        for (int i = 0; i < 16; i++) begin
            pop(1);
            check("t2_wrap", 1, 32'(rd_data[DW +: DW]), 32'(8'h80 + i));
        end
        check("t2_empty", 1, 32'(empty[1]), 32'd1);

        // 3. Simultaneous read/write on ch2.
        for (int i = 0; i < 8; i++) put(2, DW'(i));
        for (int i = 0; i < 20; i++) begin
            idle();
            wr_en[2] = 1'b1; rd_en[2] = 1'b1;
            wr_data[2*DW +: DW] = DW'(8'h20 + i);
            tick();
        end
        check("t3_count8", 2, 32'(count[2*CW +: CW]), 32'd8);
        for (int i = 0; i < 8; i++) put(2, DW'(8'hC0 + i));
        idle(); wr_en[2] = 1'b1; rd_en[2] = 1'b1; wr_data[2*DW +: DW] = 8'hEE; tick();
        check("t3_full_count15", 2, 32'(count[2*CW +: CW]), 32'd15);
        check("t3_full_ovf", 2, 32'(overflow[2]), 32'd1);
        for (int i = 0; i < 15; i++) pop(2);
        idle(); wr_en[2] = 1'b1; rd_en[2] = 1'b1; wr_data[2*DW +: DW] = 8'h77; tick();
        check("t3_empty_count1", 2, 32'(count[2*CW +: CW]), 32'd1);
        check("t3_empty_unf", 2, 32'(underflow[2]), 32'd1);
        pop(2);

        // 4. Isolation and sticky clear.
        idle(); clr_err = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            wr_en[1] = 1'b1; wr_data[DW +: DW] = DW'(8'h50 + i);
            rd_en[3] = 1'b1;
            tick();
        end
        check("t4_count1", 1, 32'(count[CW +: CW]), 32'd5);
        check("t4_unf", -1, 32'(underflow), 32'(4'b1000));
        check("t4_count0", 0, 32'(count[0 +: CW]), 32'd0);
        check("t4_count2", 2, 32'(count[2*CW +: CW]), 32'd0);
        idle(); clr_err = 1'b1; tick();
        check("t4_clr", -1, 32'(underflow), 32'd0);
        idle(); clr_err = 1'b1; rd_en[3] = 1'b1; tick();
        check("t4_set_wins", 3, 32'(underflow[3]), 32'd1);

        // 5. Flush ch3 with a concurrent write.
        for (int i = 0; i < 5; i++) put(3, DW'(8'h10 + i));
        idle(); flush[3] = 1'b1; wr_en[3] = 1'b1; wr_data[3*DW +: DW] = 8'hFF; tick();
        check("t5_flush_empty", 3, 32'(empty[3]), 32'd1);
        check("t5_sticky_kept", 3, 32'(underflow[3]), 32'd1);
        put(3, 8'h5A);
        pop(3);
        check("t5_first_word", 3, 32'(rd_data[3*DW +: DW]), 32'h5A);

        // 6. Reset mid-run, then FWFT presentation on first write.
        for (int i = 0; i < 9; i++) put(0, DW'(8'h90 + i));
        idle(); rst_n = 1'b0; wr_en = '1; rd_en = '1; tick();
        check("t6_rst_unf", -1, 32'(underflow), 32'd0);
        put(0, 8'h3C);
        check("t6_fwft_data", 0, 32'(f_rd_data[0 +: DW]), 32'h3C);
        check("t6_fwft_nonempty", 0, 32'(f_empty[0]), 32'd0);

        // Randomized traffic with phases biased toward filling or draining.
        for (int n = 0; n < 3000; n++) begin
            int wp;
            wp = ((n / 150) % 2 == 0) ? 75 : 30;
            idle();
            for (int c = 0; c < NCH; c++) begin
                wr_en[c] = ($urandom_range(99) < wp);
                rd_en[c] = ($urandom_range(99) < (105 - wp));
                flush[c] = ($urandom_range(63) == 0);
                wr_data[c*DW +: DW] = DW'($urandom);
            end
            clr_err = ($urandom_range(31) == 0);
            rst_n   = ($urandom_range(499) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
